uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter, successor to the single-byte 8N1 sender.
//  Adds a baud-rate divider, configurable data width, parity and stop bits,
//  and a small write FIFO so software/FSM producers can queue words.
//  Sits between a byte producer (CPU bridge/test FSM) and the board TX pin.
// PARAMETERS
//  CLKS_PER_BIT  16  clock cycles per serial bit; legal >= 2
//  DATA_BITS     8   payload bits per frame; legal 5..9
//  PARITY        0   0 = none, 1 = odd, 2 = even
//  STOP_BITS     1   1 or 2
//  FIFO_DEPTH    4   queued words; power of 2, >= 2
// PORTS
//  clock       in   1                   system clock, rising edge
//  reset_n     in   1                   async active-low reset
//  send        in   1                   write strobe; word pushed when send && ready
//  data        in   DATA_BITS           word to queue, sampled with send
//  ready       out  1                   FIFO not full (registered)
//  done        out  1                   FIFO empty and line idle
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently queued
//  tx          out  1                   serial line, idle high (registered)
// BEHAVIOUR
//  Reset (async assert, sync release): tx=1, done=1, ready=1, fifo_level=0,
//   FSM=IDLE, FIFO pointers cleared. Mid-frame reset aborts the frame; tx
//   goes high immediately, queued words are discarded.
//  Write: every edge with send=1 && ready=1 pushes one word (level-sensitive;
//   holding send high for N cycles pushes N words). send with ready=0 is
//   dropped, no error flag. Push and pop in the same cycle: level unchanged.
//  ready = (fifo_level != FIFO_DEPTH), updated on the same edge as the level.
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE/START.
//   IDLE: tx=1; if FIFO non-empty, pop head into shift reg, go START.
//   START: tx=0 for CLKS_PER_BIT cycles.
//   DATA: LSB first, each bit CLKS_PER_BIT cycles; bit counter 0..DATA_BITS-1.
//   PARITY (skipped if PARITY=0): odd -> total ones (data+parity) odd;
//    even -> total ones even.
//   STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; at end, if FIFO non-empty
//    pop and go directly to START (no idle gap), else IDLE.
//  Baud counter: counts 0..CLKS_PER_BIT-1, reloads at each bit boundary;
//   held at 0 in IDLE.
//  Latency: word written at edge k into empty FIFO with FSM in IDLE ->
//   start bit driven from edge k+1. fifo_level rises at edge k, falls at k+1.
//  Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT.
//  done = (FSM==IDLE) && (fifo_level==0); drops the edge after first push.
//  data is captured at push; later changes on data never affect queued words.
//  FIFO pointers wrap modulo FIFO_DEPTH; level is the separate counter.
// TESTING
//  1 Reset: assert reset_n=0 mid-run -> tx=1, done=1, ready=1, level=0 same cycle.
//  2 CLKS_PER_BIT=4, 8N1, push 0x55 -> tx: 0,1,0,1,0,1,0,1,0,1 each 4 cycles,
//    done low 41 cycles (1 queue cycle + 40-cycle frame), then done=1.
//  3 PARITY=2, push 0x07 -> parity bit 1; PARITY=1, push 0x07 -> parity bit 0.
//  4 DEPTH=4, send high 6 consecutive cycles with 0xA0..0xA5 -> 0xA0..0xA4
//    accepted, ready low at 6th, 0xA5 dropped; 5 frames back-to-back, no idle gap.
//  5 DATA_BITS=7, STOP_BITS=2, push 0x41 -> 7 data bits then tx=1 for 2 bit times.
//  6 Reset released after abort, push 0x3C -> clean full frame, no residue.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO: configurable baud divider, data width,
// parity and stop bits. Frames go out back to back while words remain queued.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          send,
  input  logic [DATA_BITS-1:0]          data,
  output logic                          ready,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS) + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     level_next;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  state_t               state, state_next;
  logic [CNT_W-1:0]     baud_cnt, baud_next;
  logic [BIT_W-1:0]     bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_bit, parity_next;
  logic                 tx_next;
  logic                 baud_tick;

  assign push       = send && ready;
  assign head       = mem[rd_ptr];
  assign level_next = fifo_level + LVL_W'(push) - LVL_W'(pop);
  assign baud_tick  = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign done       = (state == S_IDLE) && (fifo_level == '0);

  // Storage has no reset; the pointers and level alone define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ready      <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level <= level_next;
      ready      <= (level_next != LVL_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      shift_reg  <= shift_next;
      parity_bit <= parity_next;
      tx         <= tx_next;
    end
  end

  // tx is registered, so it is derived from the state being entered, not the current one.
  always_comb begin
    state_next  = state;
    baud_next   = baud_cnt;
    bit_next    = bit_cnt;
    shift_next  = shift_reg;
    parity_next = parity_bit;
    pop         = 1'b0;

    case (state)
      S_IDLE: begin
        baud_next = '0;
        if (fifo_level != '0) begin
          pop         = 1'b1;
          shift_next  = head;
          parity_next = (PARITY == 1) ? ~(^head) : (^head);
          bit_next    = '0;
          state_next  = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = S_DATA;
        end else begin
          baud_next = baud_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          baud_next  = '0;
          shift_next = shift_reg >> 1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_next   = '0;
            state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_next = bit_cnt + BIT_W'(1);
          end
        end else begin
          baud_next = baud_cnt + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = S_STOP;
        end else begin
          baud_next = baud_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          baud_next = '0;
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            bit_next = '0;
            if (fifo_level != '0) begin
              pop         = 1'b1;
              shift_next  = head;
              parity_next = (PARITY == 1) ? ~(^head) : (^head);
              state_next  = S_START;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            bit_next = bit_cnt + BIT_W'(1);
          end
        end else begin
          baud_next = baud_cnt + CNT_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase

    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
      S_PARITY: tx_next = parity_next;
      default:  tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four differently configured instances checked every cycle
// against a frame-level model, plus hand-computed frame and timing expectations.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  int cfg_db   [4] = '{8, 8, 8, 7};
  int cfg_par  [4] = '{0, 2, 1, 0};
  int cfg_stop [4] = '{1, 1, 1, 2};

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       send_v  [4];
  logic [8:0] data_v  [4];
  logic       tx_v    [4];
  logic       done_v  [4];
  logic       ready_v [4];
  logic [2:0] lvl_v   [4];

  int tests = 0;
  int fails = 0;

  int m_q    [4][8];
  int m_cnt  [4];
  bit m_busy [4];
  int m_el   [4];
  int m_bits [4][16];
  int m_len  [4];
  bit mp_push, mp_have;

  int tr_tx   [4][64];
  int tr_done [4][64];

  always #5 clock = ~clock;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_n81 (
    .clock(clock), .reset_n(reset_n), .send(send_v[0]), .data(data_v[0][7:0]),
    .ready(ready_v[0]), .done(done_v[0]), .fifo_level(lvl_v[0]), .tx(tx_v[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_even (
    .clock(clock), .reset_n(reset_n), .send(send_v[1]), .data(data_v[1][7:0]),
    .ready(ready_v[1]), .done(done_v[1]), .fifo_level(lvl_v[1]), .tx(tx_v[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_odd (
    .clock(clock), .reset_n(reset_n), .send(send_v[2]), .data(data_v[2][7:0]),
    .ready(ready_v[2]), .done(done_v[2]), .fifo_level(lvl_v[2]), .tx(tx_v[2]));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_72 (
    .clock(clock), .reset_n(reset_n), .send(send_v[3]), .data(data_v[3][6:0]),
    .ready(ready_v[3]), .done(done_v[3]), .fifo_level(lvl_v[3]), .tx(tx_v[3]));

  task automatic check_output(input string name, input int inst, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s inst%0d: got %0d, expected %0d", name, inst, act, exp);
    end
  endtask

  // Model: pop the head word and lay out its whole frame as a list of bit values.
  task automatic model_load(input int i);
    int word, ones, n;
    word = m_q[i][0];
    for (int k = 0; k < 7; k++) m_q[i][k] = m_q[i][k + 1];
    m_cnt[i] = m_cnt[i] - 1;
    n = 0;
    ones = 0;
    m_bits[i][n] = 0;
    n = n + 1;
    for (int b = 0; b < cfg_db[i]; b++) begin
      m_bits[i][n] = (word >> b) & 1;
      ones = ones + m_bits[i][n];
      n = n + 1;
    end
    if (cfg_par[i] == 1) begin
      m_bits[i][n] = (ones % 2 == 0) ? 1 : 0;
      n = n + 1;
    end else if (cfg_par[i] == 2) begin
      m_bits[i][n] = ones % 2;
      n = n + 1;
    end
    for (int s = 0; s < cfg_stop[i]; s++) begin
      m_bits[i][n] = 1;
      n = n + 1;
    end
    m_len[i]  = n * CPB;
    m_busy[i] = 1'b1;
    m_el[i]   = 0;
  endtask

  always @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset_n) begin
        m_cnt[i]  = 0;
        m_busy[i] = 1'b0;
        m_el[i]   = 0;
      end else begin
        mp_push = send_v[i] && (m_cnt[i] != DEPTH);
        mp_have = (m_cnt[i] > 0);
        if (!m_busy[i]) begin
          if (mp_have) model_load(i);
        end else if (m_el[i] == m_len[i] - 1) begin
          if (mp_have) model_load(i);
          else m_busy[i] = 1'b0;
        end else begin
          m_el[i] = m_el[i] + 1;
        end
        if (mp_push) begin
          m_q[i][m_cnt[i]] = int'(data_v[i]) & ((1 << cfg_db[i]) - 1);
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      for (int i = 0; i < 4; i++) begin
        check_output("tx", i, int'(tx_v[i]), m_busy[i] ? m_bits[i][m_el[i] / CPB] : 1);
        check_output("done", i, int'(done_v[i]), (!m_busy[i] && m_cnt[i] == 0) ? 1 : 0);
        check_output("ready", i, int'(ready_v[i]), (m_cnt[i] != DEPTH) ? 1 : 0);
        check_output("fifo_level", i, int'(lvl_v[i]), m_cnt[i]);
      end
    end
  end

  task automatic apply_stimulus(input bit [3:0] mask, input logic [8:0] w0, input logic [8:0] w1,
                                input logic [8:0] w2, input logic [8:0] w3);
    @(negedge clock);
    send_v[0] = mask[0]; data_v[0] = w0;
    send_v[1] = mask[1]; data_v[1] = w1;
    send_v[2] = mask[2]; data_v[2] = w2;
    send_v[3] = mask[3]; data_v[3] = w3;
    @(negedge clock);
    for (int i = 0; i < 4; i++) send_v[i] = 1'b0;
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < 4; i++) begin
        tr_tx[i][c]   = int'(tx_v[i]);
        tr_done[i][c] = int'(done_v[i]);
      end
      @(negedge clock);
    end
  endtask

  task automatic check_frame(input int i, input int nb, input logic [10:0] exp_vec, input int exp_low);
    int low;
    for (int b = 0; b < nb; b++) check_output("frame_bit", i, tr_tx[i][4 * b + 2], int'(exp_vec[b]));
    low = 0;
    while (low < 60 && tr_done[i][low] == 0) low++;
    check_output("done_low_cycles", i, low, exp_low);
  endtask

  task automatic check_reset_values();
    for (int i = 0; i < 4; i++) begin
      check_output("reset_tx", i, int'(tx_v[i]), 1);
      check_output("reset_done", i, int'(done_v[i]), 1);
      check_output("reset_ready", i, int'(ready_v[i]), 1);
      check_output("reset_level", i, int'(lvl_v[i]), 0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ready_pre [6];
    int accepted, low, guard;

    for (int i = 0; i < 4; i++) begin
      send_v[i] = 1'b0;
      data_v[i] = '0;
    end
    repeat (2) @(negedge clock);
    #1 check_reset_values();
    @(negedge clock);
    #2 reset_n = 1'b1;

    // 8N1 0x55, even/odd parity 0x07, 7-bit two-stop 0x41, all at once.
    apply_stimulus(4'b1111, 9'h055, 9'h007, 9'h007, 9'h041);
    check_frame(0, 10, 11'b01010101010, 41);
    check_frame(1, 11, 11'b11000001110, 45);
    check_frame(2, 11, 11'b10000001110, 45);
    check_frame(3, 10, 11'b01110000010, 41);

    // Six consecutive sends into a depth-4 FIFO: five accepted, frames back to back.
    low = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      if (n > 0 && !done_v[0]) low++;
      ready_pre[n] = int'(ready_v[0]);
      send_v[0] = 1'b1;
      data_v[0] = 9'h0A0 + 9'(n);
    end
    @(negedge clock);
    send_v[0] = 1'b0;
    accepted = 0;
    for (int n = 0; n < 6; n++) accepted += ready_pre[n];
    check_output("ready_at_6th_send", 0, ready_pre[5], 0);
    check_output("words_accepted", 0, accepted, 5);
    guard = 0;
    while (!done_v[0] && guard < 400) begin
      low++;
      guard++;
      @(negedge clock);
    end
    check_output("burst_done_bound", 0, (guard < 400) ? 1 : 0, 1);
    check_output("burst_done_low_cycles", 0, low, 201);

    // Mid-frame reset with words still queued.
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      send_v[0] = 1'b1;
      data_v[0] = 9'h011;
    end
    @(negedge clock);
    send_v[0] = 1'b0;
    check_output("pre_reset_tx", 0, int'(tx_v[0]), 0);
    check_output("pre_reset_level", 0, int'(lvl_v[0]), 2);
    #2 reset_n = 1'b0;
    #1 check_reset_values();
    repeat (2) @(negedge clock);
    #1 check_reset_values();
    @(negedge clock);
    #2 reset_n = 1'b1;

    // Clean frame after the abort.
    apply_stimulus(4'b0001, 9'h03C, 9'h000, 9'h000, 9'h000);
    check_frame(0, 10, 11'b01001111000, 41);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
